afe_sample_seq: RTL and testbench

- Upstream conversion sequencer that drives the sensor AFE and feeds the DFE sensor-data input (sens_data_i / sens_data_i_val).
- Powers the AFE, waits a settle time, then issues periodic start-of-conversion pulses.
- Captures each result on end-of-conversion and presents it as a one-cycle valid strobe.
- Honours the POWERDOWN bit of sens_mode and flags conversions that never complete.

---
 rtl/afe_sample_seq.sv | 155 +++++++++++++++
 tb/tb_afe_sample_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_sample_seq.sv
// AFE conversion sequencer: power-up settle, periodic SOC, EOC capture, timeout flag.
// Define AFE_AVG4_EN to emit one averaged sample per four successful conversions.
module afe_sample_seq #(
    parameter int DATA_WIDTH     = 8,
    parameter int PERIOD_WIDTH   = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    powerdown_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    afe_en_o,
    output logic                    afe_soc_o,
    input  logic                    afe_eoc_i,
    input  logic [DATA_WIDTH-1:0]   afe_data_i,
    output logic [DATA_WIDTH-1:0]   sens_data_o,
    output logic                    sens_data_o_val,
    output logic                    busy_o,
    output logic                    timeout_err_o,
    input  logic                    err_clr_i
);

    typedef enum logic [2:0] {
        S_OFF,
        S_SETTLE,
        S_CONVERT,
        S_WAIT_EOC,
        S_IDLE
    } state_t;

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state, next_state;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [PERIOD_WIDTH-1:0] elapsed;
    logic                    eoc_hit;
    logic                    timeout_hit;
    logic                    period_done;

    // Widened by one bit so a saturated elapsed count still compares correctly.
    assign period_done = ({1'b0, elapsed} + (PERIOD_WIDTH+1)'(1)) >= {1'b0, period_i};

`ifdef AFE_AVG4_EN
    logic [DATA_WIDTH+1:0] acc;
    logic [DATA_WIDTH+1:0] acc_sum;
    logic [1:0]            avg_cnt;
    assign acc_sum = acc + {2'b00, afe_data_i};
`endif

    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        eoc_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_OFF: begin
                next_state = S_SETTLE;
                cnt_next   = '0;
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    next_state = S_CONVERT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_CONVERT: begin
                next_state = S_WAIT_EOC;
                cnt_next   = '0;
            end
            S_WAIT_EOC: begin
                // A result arriving on the final wait cycle still counts as a success.
                if (afe_eoc_i) begin
                    eoc_hit    = 1'b1;
                    next_state = S_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = S_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (period_done) next_state = S_CONVERT;
            end
            default: next_state = S_OFF;
        endcase
        if (powerdown_i) begin
            next_state  = S_OFF;
            cnt_next    = '0;
            eoc_hit     = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_OFF;
            cnt             <= '0;
            elapsed         <= '0;
            afe_en_o        <= 1'b0;
            afe_soc_o       <= 1'b0;
            busy_o          <= 1'b0;
            timeout_err_o   <= 1'b0;
            sens_data_o     <= '0;
            sens_data_o_val <= 1'b0;
`ifdef AFE_AVG4_EN
            acc             <= '0;
            avg_cnt         <= '0;
`endif
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            afe_en_o  <= (next_state != S_OFF);
            afe_soc_o <= (next_state == S_CONVERT);
            busy_o    <= (next_state == S_SETTLE) || (next_state == S_CONVERT) ||
                         (next_state == S_WAIT_EOC);

            if (next_state == S_CONVERT) elapsed <= '0;
            else if (!(&elapsed))        elapsed <= elapsed + PERIOD_WIDTH'(1);

            if (timeout_hit)    timeout_err_o <= 1'b1;
            else if (err_clr_i) timeout_err_o <= 1'b0;

            sens_data_o_val <= 1'b0;
`ifdef AFE_AVG4_EN
            if (powerdown_i || timeout_hit) begin
                acc     <= '0;
                avg_cnt <= '0;
            end else if (eoc_hit) begin
                if (avg_cnt == 2'd3) begin
                    sens_data_o     <= acc_sum[DATA_WIDTH+1:2];
                    sens_data_o_val <= 1'b1;
                    acc             <= '0;
                    avg_cnt         <= '0;
                end else begin
                    acc     <= acc_sum;
                    avg_cnt <= avg_cnt + 2'd1;
                end
            end
`else
            if (eoc_hit) begin
                sens_data_o     <= afe_data_i;
                sens_data_o_val <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_afe_sample_seq.sv
// Bench for afe_sample_seq: event-level model of SOC timing, captured data and the error flag.
// Honours AFE_AVG4_EN when the design is built with it.
module tb_afe_sample_seq;

    localparam int DW = 8;
    localparam int PW = 16;
    localparam int SC = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          powerdown_i;
    logic [PW-1:0] period_i;
    logic          afe_en_o;
    logic          afe_soc_o;
    logic          afe_eoc_i;
    logic [DW-1:0] afe_data_i;
    logic [DW-1:0] sens_data_o;
    logic          sens_data_o_val;
    logic          busy_o;
    logic          timeout_err_o;
    logic          err_clr_i;

    afe_sample_seq #(
        .DATA_WIDTH    (DW),
        .PERIOD_WIDTH  (PW),
        .SETTLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .powerdown_i    (powerdown_i),
        .period_i       (period_i),
        .afe_en_o       (afe_en_o),
        .afe_soc_o      (afe_soc_o),
        .afe_eoc_i      (afe_eoc_i),
        .afe_data_i     (afe_data_i),
        .sens_data_o    (sens_data_o),
        .sens_data_o_val(sens_data_o_val),
        .busy_o         (busy_o),
        .timeout_err_o  (timeout_err_o),
        .err_clr_i      (err_clr_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: every SOC schedules its own outcome (result or timeout) and the next SOC.
    bit            on = 1'b0;
    int            exp_soc = -1;
    int            eoc_at = -1;
    int            err_set_at = -1;
    int            busy_until = 0;
    int            clr_at = -1;
    int            period = 20;
    int            dly = 3;
    int            next_period = 20;
    int            next_dly = 3;
    bit            pd = 1'b0;
    bit            rst_req = 1'b1;
    bit            noise = 1'b0;
    bit            rnd = 1'b0;
    bit            exp_err = 1'b0;
    bit            val_next = 1'b0;
    logic [DW-1:0] hold = '0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] force_q[$];
    int            grp_sum = 0;
    int            grp_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit            eoc_real;
        bit            err_next;
        logic [DW-1:0] d;
        int            path;
        rst         = rst_req;
        powerdown_i = pd;
        err_clr_i   = (cyc == clr_at);
        period_i    = PW'(period);
        d           = DW'($urandom_range(0, 255));
        eoc_real    = !rst_req && on && (eoc_at == cyc);
        if (eoc_real && force_q.size() > 0) d = force_q.pop_front();
        afe_data_i  = d;
        afe_eoc_i   = eoc_real ||
                      (noise && on && cyc >= busy_until && cyc < exp_soc && $urandom_range(0, 2) == 0);

        val_next = 1'b0;
        err_next = exp_err;
        if (rst_req) begin
            on = 1'b0; exp_soc = -1; eoc_at = -1; err_set_at = -1; busy_until = 0;
            err_next = 1'b0; hold = '0; grp_sum = 0; grp_n = 0;
            exp_q.delete();
        end else if (pd) begin
            on = 1'b0; exp_soc = -1; eoc_at = -1; err_set_at = -1; busy_until = 0;
            grp_sum = 0; grp_n = 0;
            if (cyc == clr_at) err_next = 1'b0;
        end else begin
            if (!on) begin
                on = 1'b1;
                exp_soc = cyc + SC + 1;
                busy_until = 1 << 30;
            end
            if (err_set_at == cyc + 1) begin
                err_next = 1'b1;
                grp_sum = 0;
                grp_n = 0;
            end else if (cyc == clr_at) begin
                err_next = 1'b0;
            end
            if (eoc_real) begin
`ifdef AFE_AVG4_EN
                grp_sum += int'(d);
                grp_n++;
                if (grp_n == 4) begin
                    exp_q.push_back(DW'(grp_sum / 4));
                    val_next = 1'b1;
                    grp_sum = 0;
                    grp_n = 0;
                end
`else
                exp_q.push_back(d);
                val_next = 1'b1;
`endif
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        exp_err = err_next;

        chk("afe_en", 32'(afe_en_o), 32'(on));
        chk("soc", 32'(afe_soc_o), 32'(cyc == exp_soc));
        chk("busy", 32'(busy_o), 32'(on && (cyc < busy_until || cyc == exp_soc)));
        chk("timeout_err", 32'(timeout_err_o), 32'(exp_err));
        chk("val", 32'(sens_data_o_val), 32'(val_next));
        if (val_next && exp_q.size() > 0) hold = exp_q.pop_front();
        chk("data", 32'(sens_data_o), 32'(hold));

        if (on && cyc == exp_soc) begin
            period = next_period;
            dly    = next_dly;
            if (dly > 0) begin
                eoc_at = cyc + dly;
                path   = dly + 2;
            end else begin
                eoc_at     = -1;
                err_set_at = cyc + TO + 1;
                path       = TO + 2;
            end
            busy_until = cyc + path - 1;
            exp_soc    = cyc + ((period > path) ? period : path);
            if (rnd) begin
                next_period = $urandom_range(0, 24);
                next_dly    = $urandom_range(0, TO);
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; powerdown_i = 1'b0; period_i = '0; afe_eoc_i = 1'b0;
        afe_data_i = '0; err_clr_i = 1'b0;

        // Reset for two cycles, then power-up and periodic sampling at period 20.
        rst_req = 1'b1;
        repeat (2) cycle();
        rst_req = 1'b0;
        force_q.push_back(8'd10);
        force_q.push_back(8'd11);
        force_q.push_back(8'd12);
        force_q.push_back(8'd14);
        force_q.push_back(8'h5A);
        force_q.push_back(8'hA5);
        repeat (130) cycle();

        // Back-to-back conversions.
        next_period = 0;
        next_dly = 2;
        repeat (60) cycle();

        // Timeouts: flag rises, clears on request, and wins against a coincident clear.
        next_period = 12;
        next_dly = 0;
        n = 0;
        while (timeout_err_o !== 1'b1 && n < 100) begin cycle(); n++; end
        chk("timeout_seen", 32'(timeout_err_o), 32'(1));
        clr_at = cyc;
        cycle();
        chk("err_cleared", 32'(timeout_err_o), 32'(0));
        n = 0;
        while (err_set_at <= cyc && n < 40) begin cycle(); n++; end
        clr_at = err_set_at - 1;
        n = 0;
        while (cyc <= clr_at && n < 40) begin cycle(); n++; end
        chk("err_set_over_clr", 32'(timeout_err_o), 32'(1));
        clr_at = cyc;
        cycle();

        // Powerdown coincident with an end-of-conversion.
        next_period = 20;
        next_dly = 3;
        n = 0;
        while (eoc_at != cyc && n < 80) begin cycle(); n++; end
        chk("eoc_reached", 32'(eoc_at == cyc), 32'(1));
        force_q.delete();
        force_q.push_back(8'h33);
        pd = 1'b1;
        cycle();
        chk("pd_no_val", 32'(sens_data_o_val), 32'(0));
        repeat (3) cycle();
        pd = 1'b0;
        repeat (30) cycle();

        // Randomized periods, delays and timeouts with spurious eoc outside WAIT_EOC.
        rnd = 1'b1;
        noise = 1'b1;
        repeat (250) cycle();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        repeat (300) cycle();
        pd = 1'b1;
        repeat (2) cycle();
        pd = 1'b0;
        repeat (150) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
